// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer
//   Pulls full-width words from the head of an upstream FIFO and replays each
//   one as N = p_word_bits/p_beat_bits narrower beats on a val/rdy stream,
//   least-significant beat first, with out_last flagging the final beat.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   fifo_empty  upstream FIFO empty flag
//   fifo_rdata  upstream FIFO head entry (valid while fifo_empty is 0)
//   fifo_pop    removes the FIFO head at the next rising edge
//   out_val     a beat is being offered
//   out_rdy     consumer accepts the beat
//   out_msg     beat data
//   out_last    current beat is the final beat of its word
module fifo_word_serializer #(
    parameter int p_word_bits = 32,
    parameter int p_beat_bits = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [p_word_bits-1:0] fifo_rdata,
    output logic                   fifo_pop,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_beat_bits-1:0] out_msg,
    output logic                   out_last
);

    localparam int N     = p_word_bits / p_beat_bits;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SLOTS = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Word padded to a power-of-two number of beat slots so that any value
    // of idx_q indexes a real slot.
    typedef logic [SLOTS*p_beat_bits-1:0] padded_t;

    generate
        if (p_word_bits % p_beat_bits != 0) begin : g_width_check
            $error("fifo_word_serializer: p_word_bits must be a multiple of p_beat_bits");
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [p_word_bits-1:0] word_q, word_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SLOTS-1:0][p_beat_bits-1:0] slots;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    assign slots = padded_t'(word_q);

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        out_val  = (state_q == SEND);
        out_msg  = slots[idx_q];
        // Qualified by SEND so that with N = 1 (idx 0 == last) the flag
        // still reads 0 out of reset.
        out_last = (state_q == SEND) && (idx_q == LAST_IDX);

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    word_d   = fifo_rdata;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (out_rdy) begin
                    if (idx_q == LAST_IDX) begin
                        // Chain straight into the next word when one is
                        // waiting so consecutive words leave no bubble.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            word_d   = fifo_rdata;
                            idx_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
module tb_fifo_word_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A: 32-bit words, 8-bit beats ----------------
    logic        a_push;
    logic [31:0] a_wdata;
    logic        a_empty, a_pop, a_val, a_rdy, a_last;
    logic [31:0] a_rdata;
    logic [7:0]  a_msg;

    logic [31:0] a_mem [4];
    logic [1:0]  a_wp, a_rp;
    logic [2:0]  a_cnt;
    logic        a_push_ok, a_pop_ok;

    assign a_empty   = (a_cnt == 3'd0);
    assign a_rdata   = a_mem[a_rp];
    assign a_push_ok = a_push && (a_cnt != 3'd4);
    assign a_pop_ok  = a_pop && (a_cnt != 3'd0);

    always_ff @(posedge clk or posedge (~rst)) begin
        if (!rst) begin
            a_wp <= '0; a_rp <= '0; a_cnt <= '0;
        end else begin
            if (a_push_ok) begin
                a_mem[a_wp] <= a_wdata;
                a_wp <= a_wp + 2'd1;
            end
            if (a_pop_ok) a_rp <= a_rp + 2'd1;
            a_cnt <= a_cnt + 3'(a_push_ok) - 3'(a_pop_ok);
        end
    end

    fifo_word_serializer #(.p_word_bits(32), .p_beat_bits(8)) dut_a (
        .clk(clk), .rst(rst), .fifo_empty(a_empty), .fifo_rdata(a_rdata),
        .fifo_pop(a_pop), .out_val(a_val), .out_rdy(a_rdy),
        .out_msg(a_msg), .out_last(a_last)
    );

    // ---------------- DUT B: N = 1 pass-through ----------------
    logic        b_push;
    logic [31:0] b_wdata;
    logic        b_empty, b_pop, b_val, b_rdy, b_last;
    logic [31:0] b_rdata, b_msg;

    logic [31:0] b_mem [4];
    logic [1:0]  b_wp, b_rp;
    logic [2:0]  b_cnt;
    logic        b_push_ok, b_pop_ok;

    assign b_empty   = (b_cnt == 3'd0);
    assign b_rdata   = b_mem[b_rp];
    assign b_push_ok = b_push && (b_cnt != 3'd4);
    assign b_pop_ok  = b_pop && (b_cnt != 3'd0);

    always_ff @(posedge clk or posedge (~rst)) begin
        if (!rst) begin
            b_wp <= '0; b_rp <= '0; b_cnt <= '0;
        end else begin
            if (b_push_ok) begin
                b_mem[b_wp] <= b_wdata;
                b_wp <= b_wp + 2'd1;
            end
            if (b_pop_ok) b_rp <= b_rp + 2'd1;
            b_cnt <= b_cnt + 3'(b_push_ok) - 3'(b_pop_ok);
        end
    end

    fifo_word_serializer #(.p_word_bits(32), .p_beat_bits(32)) dut_b (
        .clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_rdata(b_rdata),
        .fifo_pop(b_pop), .out_val(b_val), .out_rdy(b_rdy),
        .out_msg(b_msg), .out_last(b_last)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        push;
        logic [31:0] wdata;
        logic        rdy;
        logic        val;
        logic [7:0]  msg;
        logic        last;
        logic        pop;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic push, input logic [31:0] wdata, input logic rdy,
                     input logic val, input logic [7:0] msg, input logic last,
                     input logic pop);
        vec_t e;
        e.push = push; e.wdata = wdata; e.rdy = rdy;
        e.val = val; e.msg = msg; e.last = last; e.pop = pop;
        tbl.push_back(e);
    endtask

    // expected beats for the hand-written sequences
    logic [7:0]  exp_beats [4];
    logic [31:0] exp_b     [3];

    initial begin
        a_push = 0; a_wdata = '0; a_rdy = 1;
        b_push = 0; b_wdata = '0; b_rdy = 1;

        // ---- reset state ----
        @(negedge clk); #1;
        chk("rst_a_val",  32'(a_val),  32'd0);
        chk("rst_a_msg",  32'(a_msg),  32'd0);
        chk("rst_a_last", 32'(a_last), 32'd0);
        chk("rst_a_pop",  32'(a_pop),  32'd0);
        chk("rst_b_val",  32'(b_val),  32'd0);
        chk("rst_b_msg",  b_msg,       32'd0);
        chk("rst_b_last", 32'(b_last), 32'd0);
        @(negedge clk);
        rst = 1;

        // ---- table: idle, single word, backpressure, back-to-back ----
        //   push wdata          rdy val msg   last pop
        for (int i = 0; i < 5; i++) v(0, 32'h0, 1, 0, 8'h00, 0, 0);   // idle
        v(1, 32'hdeadbeef, 1, 0, 8'h00, 0, 0);
        v(0, 32'h0,        1, 0, 8'h00, 0, 1);                        // pop in IDLE
        v(0, 32'h0,        1, 1, 8'hef, 0, 0);
        v(0, 32'h0,        1, 1, 8'hbe, 0, 0);
        v(0, 32'h0,        1, 1, 8'had, 0, 0);
        v(0, 32'h0,        1, 1, 8'hde, 1, 0);
        v(0, 32'h0,        1, 0, 8'h00, 0, 0);
        v(1, 32'hdeadbeef, 1, 0, 8'h00, 0, 0);                        // backpressure
        v(0, 32'h0,        1, 0, 8'h00, 0, 1);
        v(0, 32'h0,        1, 1, 8'hef, 0, 0);
        v(0, 32'h0,        0, 1, 8'hbe, 0, 0);
        v(0, 32'h0,        0, 1, 8'hbe, 0, 0);
        v(0, 32'h0,        0, 1, 8'hbe, 0, 0);
        v(0, 32'h0,        1, 1, 8'hbe, 0, 0);
        v(0, 32'h0,        1, 1, 8'had, 0, 0);
        v(0, 32'h0,        1, 1, 8'hde, 1, 0);
        v(0, 32'h0,        1, 0, 8'h00, 0, 0);
        v(1, 32'h03020100, 1, 0, 8'h00, 0, 0);                        // back-to-back
        v(1, 32'h07060504, 1, 0, 8'h00, 0, 1);
        v(0, 32'h0,        1, 1, 8'h00, 0, 0);
        v(0, 32'h0,        1, 1, 8'h01, 0, 0);
        v(0, 32'h0,        1, 1, 8'h02, 0, 0);
        v(0, 32'h0,        1, 1, 8'h03, 1, 1);                        // chained pop
        v(0, 32'h0,        1, 1, 8'h04, 0, 0);
        v(0, 32'h0,        1, 1, 8'h05, 0, 0);
        v(0, 32'h0,        1, 1, 8'h06, 0, 0);
        v(0, 32'h0,        1, 1, 8'h07, 1, 0);
        v(0, 32'h0,        1, 0, 8'h00, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            a_push = tbl[i].push; a_wdata = tbl[i].wdata; a_rdy = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_val", i), 32'(a_val), 32'(tbl[i].val));
            chk($sformatf("v%0d_pop", i), 32'(a_pop), 32'(tbl[i].pop));
            if (tbl[i].val) begin
                chk($sformatf("v%0d_msg", i),  32'(a_msg),  32'(tbl[i].msg));
                chk($sformatf("v%0d_last", i), 32'(a_last), 32'(tbl[i].last));
            end
        end
        chk("b2b_fifo_empty", 32'(a_empty), 32'd1);
        a_push = 0;

        // ---- reset mid-word ----
        @(negedge clk); a_push = 1; a_wdata = 32'hdeadbeef; a_rdy = 1;
        @(negedge clk); a_push = 0; #1;
        chk("rmw_pop", 32'(a_pop), 32'd1);
        @(negedge clk); #1;
        chk("rmw_ef", 32'(a_msg), 32'hef);
        @(negedge clk); #1;
        chk("rmw_be", 32'(a_msg), 32'hbe);
        @(posedge clk); #2;                  // beat be accepted on this edge
        chk("rmw_pre_val", 32'(a_val), 32'd1);
        rst = 0; #1;
        chk("rmw_val_async", 32'(a_val),  32'd0);
        chk("rmw_msg_async", 32'(a_msg),  32'd0);
        chk("rmw_pop_async", 32'(a_pop),  32'd0);
        @(negedge clk); rst = 1; #1;
        chk("rmw_dropped", 32'(a_val), 32'd0);
        @(negedge clk); a_push = 1; a_wdata = 32'h11223344;
        @(negedge clk); a_push = 0; #1;
        chk("rmw2_pop", 32'(a_pop), 32'd1);
        exp_beats[0] = 8'h44; exp_beats[1] = 8'h33;
        exp_beats[2] = 8'h22; exp_beats[3] = 8'h11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk($sformatf("rmw2_val%0d", k),  32'(a_val),  32'd1);
            chk($sformatf("rmw2_msg%0d", k),  32'(a_msg),  32'(exp_beats[k]));
            chk($sformatf("rmw2_last%0d", k), 32'(a_last), (k == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk); #1;
        chk("rmw2_idle", 32'(a_val), 32'd0);

        // ---- N = 1 configuration ----
        exp_b[0] = 32'ha; exp_b[1] = 32'hb; exp_b[2] = 32'hc;
        @(negedge clk); b_push = 1; b_wdata = 32'ha; #1;
        chk("n1_c0_val", 32'(b_val), 32'd0);
        @(negedge clk); b_push = 1; b_wdata = 32'hb; #1;
        chk("n1_c1_val", 32'(b_val), 32'd0);
        chk("n1_c1_pop", 32'(b_pop), 32'd1);
        @(negedge clk); b_push = 1; b_wdata = 32'hc; #1;
        chk("n1_c2_pop", 32'(b_pop), 32'd1);
        chk("n1_c2_msg", b_msg, exp_b[0]);
        @(negedge clk); b_push = 0;
        for (int k = 1; k < 3; k++) begin
            #1;
            chk($sformatf("n1_val%0d", k),  32'(b_val),  32'd1);
            chk($sformatf("n1_msg%0d", k),  b_msg,       exp_b[k]);
            chk($sformatf("n1_last%0d", k), 32'(b_last), 32'd1);
            chk($sformatf("n1_pop%0d", k),  32'(b_pop),  (k == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        #1;
        chk("n1_idle", 32'(b_val), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
